// File: rtl/lsu_dcache_pkg.sv
// Shared definitions for the dcache fill-way selection slice: way geometry,
// set-index width default and the fill FSM state encoding.
package lsu_dcache_pkg;

  localparam int NWAY          = 4;
  localparam int WAY_W         = 2;
  localparam int DCACHE_IDX_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2,
    GNT  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/lsu_dcache_way_pick.sv
// Combinational victim-way pick: lowest invalid way, else the LFSR way.
// With LSU_DCACHE_WAY_LOCK_EN defined, locked ways are skipped (LFSR way rotates upward).
module lsu_dcache_way_pick
  import lsu_dcache_pkg::*;
(
  input  logic [NWAY-1:0]  valid,
  input  logic [NWAY-1:0]  lock,
  input  logic [WAY_W-1:0] lfsr_way,
  output logic [NWAY-1:0]  oh,
  output logic [WAY_W-1:0] enc,
  output logic             rand_sel,
  output logic             lock_ovf
);

  logic [NWAY-1:0]  free;
  logic [WAY_W-1:0] rand_enc;

`ifdef LSU_DCACHE_WAY_LOCK_EN
  assign free = ~valid & ~lock;

  // Walk downward so the nearest unlocked way above lfsr_way wins.
  always_comb begin
    rand_enc = lfsr_way;
    if (lock[lfsr_way]) begin
      for (int k = NWAY - 1; k >= 1; k--) begin
        if (!lock[lfsr_way + WAY_W'(k)]) rand_enc = lfsr_way + WAY_W'(k);
      end
    end
  end

  assign lock_ovf = rand_sel & (&lock);
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign free        = ~valid;
  assign rand_enc    = lfsr_way;
  assign lock_ovf    = 1'b0;
`endif

  always_comb begin
    rand_sel = 1'b0;
    enc      = rand_enc;
    casez (free)
      4'b???1: enc = 2'd0;
      4'b??10: enc = 2'd1;
      4'b?100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: rand_sel = 1'b1;
    endcase
  end

  assign oh = NWAY'(1) << enc;

endmodule

// File: rtl/lsu_dcache_fill_way_sel.sv
// Fill victim-way selector: reads a set's valid bits, picks a way and holds it
// until acknowledged. Optional way locking via LSU_DCACHE_WAY_LOCK_EN.
module lsu_dcache_fill_way_sel
  import lsu_dcache_pkg::*;
#(
  parameter int IDX_W = DCACHE_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_req_vld,
  input  logic [IDX_W-1:0] fill_req_idx,
  output logic             fill_req_rdy,
  output logic             vld_rd_en,
  output logic [IDX_W-1:0] vld_rd_idx,
  input  logic [NWAY-1:0]  vld_rd_data,
  input  logic [1:0]       lfsr_way,
  output logic             lfsr_advance,
  input  logic [NWAY-1:0]  way_lock,
  output logic             fill_way_vld,
  output logic [NWAY-1:0]  fill_way_oh,
  output logic [1:0]       fill_way_enc,
  output logic             fill_way_rand,
  input  logic             fill_way_ack
);

  fill_state_e      state;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] way_q;
  logic             rand_q;
  logic             rdy_q;
  logic             rd_en_q;
  logic             way_vld_q;

  logic [NWAY-1:0]  pick_oh;
  logic [WAY_W-1:0] pick_enc;
  logic             pick_rand;
  logic             pick_ovf;

  lsu_dcache_way_pick u_pick (
    .valid    (vld_rd_data),
    .lock     (way_lock),
    .lfsr_way (lfsr_way),
    .oh       (pick_oh),
    .enc      (pick_enc),
    .rand_sel (pick_rand),
    .lock_ovf (pick_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      way_q     <= '0;
      rand_q    <= 1'b0;
      rdy_q     <= 1'b1;
      rd_en_q   <= 1'b0;
      way_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fill_req_vld) begin
          idx_q   <= fill_req_idx;
          rdy_q   <= 1'b0;
          rd_en_q <= 1'b1;
          state   <= RD;
        end
        RD: begin
          rd_en_q <= 1'b0;
          state   <= WT;
        end
        WT: begin
          way_q     <= pick_enc;
          rand_q    <= pick_rand;
          way_vld_q <= 1'b1;
          state     <= GNT;
        end
        GNT: if (fill_way_ack) begin
          way_vld_q <= 1'b0;
          rdy_q     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_DCACHE_WAY_LOCK_EN
  // Sticky debug flag: an LFSR pick happened with every way locked.
  logic lock_ovf_q;
  always_ff @(posedge clk) begin
    if (reset)                         lock_ovf_q <= 1'b0;
    else if (state == WT && pick_ovf)  lock_ovf_q <= 1'b1;
  end
`else
  logic [NWAY:0] unused_pick;
  assign unused_pick = {pick_ovf, pick_oh};
`endif

  // Random state is consumed only in the read-return cycle and only on a real eviction.
  assign lfsr_advance  = (state == WT) & pick_rand;
  assign fill_req_rdy  = rdy_q;
  assign vld_rd_en     = rd_en_q;
  assign vld_rd_idx    = idx_q;
  assign fill_way_vld  = way_vld_q;
  assign fill_way_oh   = way_vld_q ? (NWAY'(1) << way_q) : '0;
  assign fill_way_enc  = way_vld_q ? way_q : '0;
  assign fill_way_rand = way_vld_q & rand_q;

endmodule

// File: tb/tb_lsu_dcache_fill_way_sel.sv
// Randomized bench for lsu_dcache_fill_way_sel against a transaction-level victim-pick model.
module tb_lsu_dcache_fill_way_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       fill_req_vld;
  logic [6:0] fill_req_idx;
  logic       fill_req_rdy;
  logic       vld_rd_en;
  logic [6:0] vld_rd_idx;
  logic [3:0] vld_rd_data;
  logic [1:0] lfsr_way;
  logic       lfsr_advance;
  logic [3:0] way_lock;
  logic       fill_way_vld;
  logic [3:0] fill_way_oh;
  logic [1:0] fill_way_enc;
  logic       fill_way_rand;
  logic       fill_way_ack;

  int errs   = 0;
  int checks = 0;

`ifdef LSU_DCACHE_WAY_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  lsu_dcache_fill_way_sel dut (
    .clk          (clk),
    .reset        (reset),
    .fill_req_vld (fill_req_vld),
    .fill_req_idx (fill_req_idx),
    .fill_req_rdy (fill_req_rdy),
    .vld_rd_en    (vld_rd_en),
    .vld_rd_idx   (vld_rd_idx),
    .vld_rd_data  (vld_rd_data),
    .lfsr_way     (lfsr_way),
    .lfsr_advance (lfsr_advance),
    .way_lock     (way_lock),
    .fill_way_vld (fill_way_vld),
    .fill_way_oh  (fill_way_oh),
    .fill_way_enc (fill_way_enc),
    .fill_way_rand(fill_way_rand),
    .fill_way_ack (fill_way_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: collect candidate invalid ways in ascending order; else LFSR way,
  // moved upward (mod 4) past locked ways when locking is enabled.
  task automatic ref_pick(input logic [3:0] v, input logic [3:0] lk, input logic [1:0] lw,
                          output int way, output bit rnd);
    int cand[$];
    for (int i = 0; i < 4; i++)
      if (!v[i] && !(LOCK_EN && lk[i])) cand.push_back(i);
    if (cand.size() > 0) begin
      way = cand[0];
      rnd = 1'b0;
    end else begin
      rnd = 1'b1;
      way = lw;
      if (LOCK_EN) begin
        for (int k = 0; k < 4; k++) begin
          if (!lk[(lw + k) % 4]) begin
            way = (lw + k) % 4;
            break;
          end
        end
      end
    end
  endtask

  task automatic do_fill(input logic [6:0] idx, input logic [3:0] vd, input logic [1:0] lw,
                         input logic [3:0] lk, input int hold, input bit pend, input bit noise);
    int  w;
    bit  rnd;
    logic [3:0] exp_oh;
    // IDLE: present request
    fill_req_vld = 1'b1;
    fill_req_idx = idx;
    #1 chk("rdy_idle", fill_req_rdy, 1);
    step();
    fill_req_vld = 1'b0;
    fill_way_ack = noise;
    #1;
    chk("rd_en", vld_rd_en, 1);
    chk("rd_idx", vld_rd_idx, idx);
    chk("rdy_busy", fill_req_rdy, 0);
    chk("adv_rd", lfsr_advance, 0);
    chk("vld_rd", fill_way_vld, 0);
    step();
    vld_rd_data = vd;
    lfsr_way    = lw;
    way_lock    = lk;
    #1;
    ref_pick(vd, lk, lw, w, rnd);
    exp_oh = 4'b0001 << w;
    chk("adv_wt", lfsr_advance, rnd);
    chk("rd_en_wt", vld_rd_en, 0);
    chk("rd_idx_hold", vld_rd_idx, idx);
    step();
    fill_way_ack = 1'b0;
    vld_rd_data  = 4'($urandom);
    lfsr_way     = 2'($urandom);
    way_lock     = 4'($urandom);
    #1;
    chk("gnt_vld", fill_way_vld, 1);
    chk("gnt_oh", fill_way_oh, exp_oh);
    chk("gnt_enc", fill_way_enc, w);
    chk("gnt_rand", fill_way_rand, rnd);
    chk("adv_gnt", lfsr_advance, 0);
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        fill_req_vld = 1'b1;
        fill_req_idx = 7'($urandom);
      end
      step();
      vld_rd_data = 4'($urandom);
      lfsr_way    = 2'($urandom);
      #1;
      chk("hold_vld", fill_way_vld, 1);
      chk("hold_oh", fill_way_oh, exp_oh);
      chk("hold_rand", fill_way_rand, rnd);
      chk("hold_rdy", fill_req_rdy, 0);
      chk("hold_rd_en", vld_rd_en, 0);
      chk("hold_adv", lfsr_advance, 0);
    end
    fill_way_ack = 1'b1;
    step();
    fill_way_ack = 1'b0;
    #1;
    chk("ack_vld", fill_way_vld, 0);
    chk("ack_oh", fill_way_oh, 0);
    chk("ack_rdy", fill_req_rdy, 1);
    chk("ack_rd_en", vld_rd_en, 0);
  endtask

  // Start a fill and reset it at the WT (stage=2) or GNT (stage=3) cycle.
  task automatic reset_mid(input int stage);
    fill_req_vld = 1'b1;
    fill_req_idx = 7'h55;
    step();
    fill_req_vld = 1'b0;
    vld_rd_data  = 4'b1111;
    for (int s = 1; s < stage; s++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_mid_rdy", fill_req_rdy, 1);
    chk("rst_mid_vld", fill_way_vld, 0);
    chk("rst_mid_oh", fill_way_oh, 0);
    chk("rst_mid_adv", lfsr_advance, 0);
    chk("rst_mid_rd_en", vld_rd_en, 0);
  endtask

  initial begin
    reset        = 1'b1;
    fill_req_vld = 1'b0;
    fill_req_idx = '0;
    vld_rd_data  = '0;
    lfsr_way     = '0;
    way_lock     = '0;
    fill_way_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_rdy", fill_req_rdy, 1);
    chk("rst_vld", fill_way_vld, 0);
    chk("rst_oh", fill_way_oh, 0);
    chk("rst_enc", fill_way_enc, 0);
    chk("rst_rand", fill_way_rand, 0);
    chk("rst_adv", lfsr_advance, 0);
    chk("rst_rd_en", vld_rd_en, 0);
    chk("rst_rd_idx", vld_rd_idx, 0);

    do_fill(7'h12, 4'b1011, 2'd1, 4'b0000, 0, 1'b0, 1'b0);
    do_fill(7'h21, 4'b1111, 2'd3, 4'b0000, 0, 1'b0, 1'b0);
    do_fill(7'h03, 4'b0000, 2'd2, 4'b0000, 0, 1'b0, 1'b1);
    do_fill(7'h04, 4'b1110, 2'd3, 4'b0000, 0, 1'b0, 1'b0);
    do_fill(7'h05, 4'b0111, 2'd0, 4'b0000, 0, 1'b0, 1'b0);
    // Long hold with a pending request; it must be taken right after the ack.
    do_fill(7'h06, 4'b1111, 2'd2, 4'b0000, 10, 1'b1, 1'b0);
    do_fill(fill_req_idx, 4'b1101, 2'd0, 4'b0000, 0, 1'b0, 1'b0);

    reset_mid(2);
    do_fill(7'h7f, 4'b1111, 2'd1, 4'b0000, 0, 1'b0, 1'b0);
    reset_mid(3);
    do_fill(7'h40, 4'b0011, 2'd0, 4'b0000, 0, 1'b0, 1'b0);

`ifdef LSU_DCACHE_WAY_LOCK_EN
    do_fill(7'h10, 4'b1111, 2'd1, 4'b1010, 0, 1'b0, 1'b0);
    do_fill(7'h11, 4'b1111, 2'd1, 4'b1111, 0, 1'b0, 1'b0);
    chk("lock_ovf", dut.lock_ovf_q, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [3:0] vd;
      vd = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
      do_fill(7'($urandom), vd, 2'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lsu_dcache_fill_way_sel.md
Name: lsu_dcache_fill_way_sel

Overview:
Consumer side of the dcache replacement LFSR. It accepts a dcache fill request for a set index, reads that set's valid bits from the valid array and picks a victim way. The pick is the lowest-index invalid way, or else the 2-bit pseudo-random way supplied by the LFSR. It pulses the LFSR advance only when the random way is actually consumed. It sits between the LSU miss/fill sequencer and the dcache valid array.

Parameters:
IDX_W, 7, dcache set-index width.
NWAY, 4, number of ways; fixed at 4 to match the 2-bit random way input.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fill_req_vld  input  1  fill request valid
fill_req_idx  input  IDX_W  set index of the fill
fill_req_rdy  output  1  request accepted when vld & rdy
vld_rd_en  output  1  valid-array read strobe
vld_rd_idx  output  IDX_W  valid-array read index
vld_rd_data  input  NWAY  valid bits; returned the cycle after vld_rd_en
lfsr_way  input  2  pseudo-random way from the replacement LFSR
lfsr_advance  output  1  single-cycle advance pulse to the LFSR
way_lock  input  NWAY  per-way lock bits; only used with the optional feature
fill_way_vld  output  1  selected way valid
fill_way_oh  output  NWAY  selected way, one-hot
fill_way_enc  output  2  selected way, encoded
fill_way_rand  output  1  selection came from the LFSR
fill_way_ack  input  1  consumer accepts the selected way

Behaviour:
- FSM states: IDLE, RD, WT, GNT; state is registered.
- IDLE:
  - fill_req_rdy=1.
  - On fill_req_vld, latch fill_req_idx into idx_q and go to RD.
- RD:
  - vld_rd_en=1 and vld_rd_idx=idx_q for exactly one cycle; go to WT.
- WT (vld_rd_data valid this cycle):
  - If any bit of vld_rd_data is 0, pick the lowest-index 0 bit and clear rand_q.
  - Otherwise pick lfsr_way, set rand_q, and pulse lfsr_advance=1 in this cycle.
  - Register the pick into way_q; go to GNT.
- GNT:
  - fill_way_vld=1; fill_way_oh, fill_way_enc and fill_way_rand are held stable.
  - On fill_way_ack, return to IDLE.
- Request-to-grant latency: accept at cycle N, fill_way_vld at N+3; minimum request spacing is 4 cycles.
- fill_req_rdy is 0 outside IDLE. An ack and a new request in the same GNT cycle: the ack completes; the request is accepted on the next (IDLE) cycle.
- lfsr_advance:
  - Never asserted outside WT.
  - Never asserted when an invalid way exists, so random state is consumed only by real evictions.
- fill_way_ack outside GNT is ignored.
- vld_rd_en is 0 and vld_rd_idx holds idx_q outside RD.
- Reset, including mid-operation:
  - State goes to IDLE; idx_q=0, way_q=0, rand_q=0.
  - Outputs: fill_req_rdy=1 in the first post-reset cycle; fill_way_vld=0, fill_way_oh=0, fill_way_enc=0, fill_way_rand=0, lfsr_advance=0, vld_rd_en=0.
  - Any in-flight pick is discarded.
- fill_way_oh is all-zero whenever fill_way_vld=0.

Optional Feature:
Macro LSU_DCACHE_WAY_LOCK_EN.
- Defined:
  - A way with way_lock=1 is never chosen as an invalid-way pick.
  - A way with way_lock=1 is never chosen as an LFSR pick: if lfsr_way is locked, use the next unlocked way in ascending modulo-4 order from lfsr_way.
  - If all four ways are locked, use lfsr_way unchanged; a 1-bit output-free flag lock_ovf_q is set for debug/assertion.
  - way_lock is sampled in WT.
- Undefined: the way_lock port is present but ignored, and there is no rotate logic.

Decomposition:
- Shared package lsu_dcache_pkg holds:
  - state encoding constants (IDLE=2'd0, RD=2'd1, WT=2'd2, GNT=2'd3);
  - NWAY and the way-encoding width;
  - dcache IDX_W default.
- One sub-module, lsu_dcache_way_pick. It is combinational and takes valid, lock and lfsr_way. It produces oh, enc and rand, and contains the priority and rotate logic. The FSM wrapper stays in the top module.

Test Plan:
- Reset, then idx=7'h12 with vld_rd_data=4'b1011 → fill_way_vld at accept+3; oh=4'b0100, enc=2, rand=0, lfsr_advance never asserted.
- vld_rd_data=4'b1111 with lfsr_way=2'd3 → oh=4'b1000, rand=1, one lfsr_advance pulse in the WT cycle only.
- vld_rd_data=4'b0000 → way 0 chosen (priority check); repeat with 4'b1110 → way 0; with 4'b0111 → way 3.
- Hold fill_way_ack=0 for 10 cycles in GNT → outputs stable, fill_req_rdy=0, a pending new request is not accepted; after ack it is accepted in the next cycle.
- Assert reset in WT and in GNT → next cycle IDLE, fill_way_vld=0, lfsr_advance=0; the next request completes normally.
- LSU_DCACHE_WAY_LOCK_EN: valid=4'b1111, lock=4'b1010, lfsr_way=1 → way 2 chosen; lock=4'b1111 → way 1 chosen and lock_ovf_q=1.
